decode_ctrl_stage: RTL

DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

---
 rtl/decode_ctrl_stage.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/decode_ctrl_stage.sv
// RV32I decode/control stage: combinational decode of the incoming word
// into a one-entry valid/ready output register, with illegal-op tracking.
module decode_ctrl_stage #(
  parameter int XLEN       = 32,
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       pc_out,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  branch,
  output logic                  jump,
  output logic                  alu_src_a_pc,
  output logic                  alu_src_b_imm,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal,
  output logic                  illegal_sticky,
  output logic [CNT_W-1:0]      illegal_cnt,
  input  logic                  clr_illegal
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  localparam logic [3:0] A_ADD  = 4'd0;
  localparam logic [3:0] A_SUB  = 4'd1;
  localparam logic [3:0] A_AND  = 4'd2;
  localparam logic [3:0] A_OR   = 4'd3;
  localparam logic [3:0] A_XOR  = 4'd4;
  localparam logic [3:0] A_SLT  = 4'd5;
  localparam logic [3:0] A_SLTU = 4'd6;
  localparam logic [3:0] A_SLL  = 4'd7;
  localparam logic [3:0] A_SRL  = 4'd8;
  localparam logic [3:0] A_SRA  = 4'd9;
  localparam logic [3:0] A_PASS = 4'd10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef struct packed {
    logic       illegal;
    logic       reg_write;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       a_pc;
    logic       b_imm;
    logic [2:0] imm_src;
    logic [1:0] result_src;
    logic [3:0] alu;
  } ctrl_t;

  function automatic logic [3:0] f3_alu(
    input logic [2:0] f3,
    input logic       sub,
    input logic       sra
  );
    logic [3:0] a;
    a = A_ADD;
    case (f3)
      3'b000:  a = sub ? A_SUB : A_ADD;
      3'b001:  a = A_SLL;
      3'b010:  a = A_SLT;
      3'b011:  a = A_SLTU;
      3'b100:  a = A_XOR;
      3'b101:  a = sra ? A_SRA : A_SRL;
      3'b110:  a = A_OR;
      default: a = A_AND;
    endcase
    return a;
  endfunction

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_zero;
  logic       f7_alt;
  ctrl_t      dec;
  logic       bad;

  assign opc     = instr[6:0];
  assign f3      = instr[14:12];
  assign f7      = instr[31:25];
  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);

  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  always_comb begin
    dec = '0;
    bad = 1'b0;
    unique case (1'b1)
      (opc == OP_R): begin
        dec.reg_write = 1'b1;
        dec.alu       = f3_alu(f3, f7[5], f7[5]);
        bad = !(f7_zero ||
                (f7_alt && (f3 == 3'b000 ||
                            f3 == 3'b101)));
      end
      (opc == OP_I): begin
        dec.reg_write = 1'b1;
        dec.b_imm     = 1'b1;
        dec.imm_src   = IMM_I;
        // shift-immediates borrow funct7; ADDI has no SUB form
        dec.alu = f3_alu(f3, 1'b0, f7[5]);
        if (f3 == 3'b001)
          bad = !f7_zero;
        else if (f3 == 3'b101)
          bad = !(f7_zero || f7_alt);
      end
      (opc == OP_LD): begin
        dec.reg_write  = 1'b1;
        dec.b_imm      = 1'b1;
        dec.imm_src    = IMM_I;
        dec.result_src = 2'b01;
        dec.alu        = A_ADD;
        bad = (f3 == 3'b011) || (f3 == 3'b110) ||
              (f3 == 3'b111);
      end
      (opc == OP_ST): begin
        dec.mem_write = 1'b1;
        dec.b_imm     = 1'b1;
        dec.imm_src   = IMM_S;
        dec.alu       = A_ADD;
        bad = (f3 > 3'b010);
      end
      (opc == OP_BR): begin
        dec.branch  = 1'b1;
        dec.imm_src = IMM_B;
        case (f3[2:1])
          2'b00:   dec.alu = A_SUB;
          2'b10:   dec.alu = A_SLT;
          default: dec.alu = A_SLTU;
        endcase
        bad = (f3[2:1] == 2'b01);
      end
      (opc == OP_JAL): begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = IMM_J;
      end
      (opc == OP_JR): begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.b_imm      = 1'b1;
        dec.imm_src    = IMM_I;
        dec.alu        = A_ADD;
        bad = (f3 != 3'b000);
      end
      (opc == OP_LUI): begin
        dec.reg_write = 1'b1;
        dec.b_imm     = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu       = A_PASS;
      end
      (opc == OP_AUI): begin
        dec.reg_write = 1'b1;
        dec.a_pc      = 1'b1;
        dec.b_imm     = 1'b1;
        dec.imm_src   = IMM_U;
        dec.alu       = A_ADD;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      bad = 1'b1;
    if (bad) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             valid_q, valid_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             ill_acc;

  assign in_ready = (!valid_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign ill_acc  = accept && dec.illegal;

  always_comb begin
    ctrl_d   = ctrl_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (flush)
      valid_d = 1'b0;
    else if (accept) begin
      valid_d = 1'b1;
      ctrl_d  = dec;
      pc_d    = pc_in;
    end else if (out_ready)
      valid_d = 1'b0;
    // a clear coincident with an illegal accept counts that accept
    if (clr_illegal) begin
      sticky_d = ill_acc;
      cnt_d    = ill_acc ? CNT_W'(1) : '0;
    end else if (ill_acc) begin
      sticky_d = 1'b1;
      if (cnt_q != '1)
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= '0;
      pc_q     <= '0;
      valid_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid      = valid_q;
  assign pc_out         = pc_q;
  assign reg_write      = ctrl_q.reg_write;
  assign mem_write      = ctrl_q.mem_write;
  assign branch         = ctrl_q.branch;
  assign jump           = ctrl_q.jump;
  assign alu_src_a_pc   = ctrl_q.a_pc;
  assign alu_src_b_imm  = ctrl_q.b_imm;
  assign imm_src        = ctrl_q.imm_src;
  assign result_src     = ctrl_q.result_src;
  assign alu_ctrl       = ALU_CTRL_W'(ctrl_q.alu);
  assign illegal        = ctrl_q.illegal;
  assign illegal_sticky = sticky_q;
  assign illegal_cnt    = cnt_q;

endmodule
